// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronises, debounces and arbitrates two push-buttons into
//               one-cycle, mutually exclusive step pulses with auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 100000,
    parameter int REPEAT_DELAY      = 25000000,
    parameter int REPEAT_PERIOD     = 5000000,
    parameter int REPEAT_ENABLE     = 1,
    parameter int BUTTON_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_button_in,
    input  logic dec_button_in,
    output logic increment_address,
    output logic decrement_address,
    output logic inc_pressed,
    output logic dec_pressed
);

    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int c_TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX) + 1;

    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_T_DELAY  = c_TMR_W'(REPEAT_DELAY);
    localparam logic [c_TMR_W-1:0] c_T_PERIOD = c_TMR_W'(REPEAT_PERIOD);
    localparam logic [c_TMR_W-1:0] c_T_ONE    = c_TMR_W'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_DELAY   = 2'd1;
    localparam logic [1:0] c_REPEAT  = 2'd2;
    localparam logic [1:0] c_LOCKOUT = 2'd3;

    // Bit 0 is the "up" button, bit 1 the "down" button throughout.
    logic [1:0] w_raw_pressed;
    logic [1:0] w_pressed;
    logic [1:0] r_pressed_q;
    logic [1:0] w_rise;

    assign w_raw_pressed = (BUTTON_ACTIVE_LOW != 0) ? ~{dec_button_in, inc_button_in}
                                                    :  {dec_button_in, inc_button_in};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_button
            logic              r_sync1;
            logic              r_sync2;
            logic              r_level;
            logic [c_DB_W-1:0] r_count;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_level <= 1'b0;
                    r_count <= '0;
                end else begin
                    r_sync1 <= w_raw_pressed[g];
                    r_sync2 <= r_sync1;
                    // Any sample agreeing with the accepted level restarts the qualification window.
                    if (r_sync2 == r_level) begin
                        r_count <= '0;
                    end else if (r_count == c_DB_LAST) begin
                        r_level <= ~r_level;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + c_DB_W'(1);
                    end
                end
            end

            assign w_pressed[g] = r_level;
        end
    endgenerate

    assign w_rise = w_pressed & ~r_pressed_q;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_owner;
    logic               w_owner_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic [1:0]         r_pulse;
    logic [1:0]         w_pulse_nxt;
    logic               w_owner_held;
    logic               w_other_held;

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_timer_nxt  = r_timer;
        w_pulse_nxt  = 2'b00;
        w_owner_held = w_pressed[r_owner];
        w_other_held = w_pressed[~r_owner];

        case (r_state)
            c_IDLE: begin
                if ((w_rise[0] && w_pressed[1]) || (w_rise[1] && w_pressed[0])) begin
                    w_state_nxt = c_LOCKOUT;
                end else if (w_rise != 2'b00) begin
                    w_pulse_nxt = w_rise;
                    w_owner_nxt = w_rise[1];
                    w_timer_nxt = c_T_DELAY;
                    w_state_nxt = (REPEAT_ENABLE != 0) ? c_DELAY : c_LOCKOUT;
                end
            end
            c_DELAY, c_REPEAT: begin
                // Release and cross-press outrank the timer so no pulse leaves with the exit.
                if (!w_owner_held) begin
                    w_state_nxt = c_IDLE;
                end else if (w_other_held) begin
                    w_state_nxt = c_LOCKOUT;
                end else if (r_timer == c_T_ONE) begin
                    w_pulse_nxt[r_owner] = 1'b1;
                    w_timer_nxt          = c_T_PERIOD;
                    w_state_nxt          = c_REPEAT;
                end else begin
                    w_timer_nxt = r_timer - c_T_ONE;
                end
            end
            c_LOCKOUT: begin
                if (w_pressed == 2'b00) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_owner     <= 1'b0;
            r_timer     <= '0;
            r_pulse     <= 2'b00;
            r_pressed_q <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_timer     <= w_timer_nxt;
            r_pulse     <= w_pulse_nxt;
            r_pressed_q <= w_pressed;
        end
    end

    assign increment_address = r_pulse[0];
    assign decrement_address = r_pulse[1];
    assign inc_pressed       = w_pressed[0];
    assign dec_pressed       = w_pressed[1];

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Scenario and randomised bench for button_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk;
    logic reset;
    logic inc_button_in;
    logic dec_button_in;
    logic increment_address;
    logic decrement_address;
    logic inc_pressed;
    logic dec_pressed;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: pipeline of synchronised samples, run length of
    // disagreement, accepted level, and an arbiter tracked with absolute due times.
    bit m_s1[2];
    bit m_s2[2];
    bit m_acc[2];
    bit m_accq[2];
    bit m_pulse[2];
    int m_run[2];
    int m_mode  = 0;   // 0 free, 1 one button owns the output, 2 locked out
    int m_owner = 0;
    int m_due   = 0;

    logic [3:0] o_v;
    logic [3:0] e_v;

    button_conditioner #(
        .DEBOUNCE_CYCLES  (DB),
        .REPEAT_DELAY     (RD),
        .REPEAT_PERIOD    (RP),
        .REPEAT_ENABLE    (1),
        .BUTTON_ACTIVE_LOW(1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .inc_button_in    (inc_button_in),
        .dec_button_in    (dec_button_in),
        .increment_address(increment_address),
        .decrement_address(decrement_address),
        .inc_pressed      (inc_pressed),
        .dec_pressed      (dec_pressed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one clock edge (pressed = 1) and advances the model for that edge.
    task automatic step(input bit inc_p, input bit dec_p, input bit rst);
        bit pin[2];
        bit held[2];
        bit rose[2];
        pin[0] = inc_p;
        pin[1] = dec_p;
        inc_button_in = ~inc_p;
        dec_button_in = ~dec_p;
        reset = rst;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_run[b] = 0;
                m_acc[b] = 1'b0; m_accq[b] = 1'b0; m_pulse[b] = 1'b0;
            end
            m_mode = 0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                held[b]    = m_acc[b];
                rose[b]    = m_acc[b] & ~m_accq[b];
                m_pulse[b] = 1'b0;
            end
            case (m_mode)
                0: begin
                    if ((rose[0] && held[1]) || (rose[1] && held[0])) begin
                        m_mode = 2;
                    end else if (rose[0] || rose[1]) begin
                        m_owner = rose[1] ? 1 : 0;
                        m_pulse[m_owner] = 1'b1;
                        m_due  = cyc + RD;
                        m_mode = 1;
                    end
                end
                1: begin
                    if (!held[m_owner]) m_mode = 0;
                    else if (held[1 - m_owner]) m_mode = 2;
                    else if (cyc == m_due) begin
                        m_pulse[m_owner] = 1'b1;
                        m_due = cyc + RP;
                    end
                end
                default: begin
                    if (!held[0] && !held[1]) m_mode = 0;
                end
            endcase
            for (int b = 0; b < 2; b++) begin
                m_accq[b] = m_acc[b];
                if (m_s2[b] != m_acc[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_acc[b] = ~m_acc[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = pin[b];
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        o_v = {increment_address, decrement_address, inc_pressed, dec_pressed};
        e_v = {m_pulse[0], m_pulse[1], m_acc[0], m_acc[1]};
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (o_v !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000", o_v);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (o_v !== e_v) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d: got %b expected %b", cyc, o_v, e_v);
            end
        end
    endtask

    task automatic test_clean_press();
        int t0;
        int rel;
        int incq[$];
        int ndec;
        t0 = cyc;
        ndec = 0;
        for (int i = 0; i < 30; i++) begin
            step(i < 10, 1'b0, 1'b0);
            rel = cyc - t0;
            n_cmp++;
            if (o_v !== e_v) begin
                n_fail++;
                $display("FAIL clean_model rel=%0d: got %b expected %b", rel, o_v, e_v);
            end
            n_cmp++;
            if (inc_pressed !== (rel >= 6 && rel <= 15)) begin
                n_fail++;
                $display("FAIL clean_inc_pressed rel=%0d: got %b expected %b", rel, inc_pressed, (rel >= 6 && rel <= 15));
            end
            if (increment_address === 1'b1) incq.push_back(rel);
            if (decrement_address !== 1'b0) ndec++;
        end
        n_cmp++;
        if (incq.size() != 1 || incq[0] != 7) begin
            n_fail++;
            $display("FAIL clean_pulse: got %p expected '{7}", incq);
        end
        n_cmp++;
        if (ndec != 0) begin
            n_fail++;
            $display("FAIL clean_no_dec: got %0d dec pulses expected 0", ndec);
        end
    endtask

    task automatic test_bounce();
        int t0;
        int rel;
        int decq[$];
        int nother;
        int runlen;
        bit lvl;
        t0 = cyc;
        nother = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, (i < 12) ? ((i / 2) % 2 == 0) : (i < 27), 1'b0);
            rel = cyc - t0;
            n_cmp++;
            if (o_v !== e_v) begin
                n_fail++;
                $display("FAIL bounce_model rel=%0d: got %b expected %b", rel, o_v, e_v);
            end
            n_cmp++;
            if (dec_pressed !== (rel >= 18 && rel <= 32)) begin
                n_fail++;
                $display("FAIL bounce_dec_pressed rel=%0d: got %b expected %b", rel, dec_pressed, (rel >= 18 && rel <= 32));
            end
            if (decrement_address === 1'b1) decq.push_back(rel);
            if (increment_address !== 1'b0) nother++;
        end
        n_cmp++;
        if (decq.size() != 1 || decq[0] != 19 || nother != 0) begin
            n_fail++;
            $display("FAIL bounce_pulse: got dec %p inc %0d expected dec '{19} inc 0", decq, nother);
        end
        // Random glitches shorter than the debounce window must never surface.
        lvl = 1'b0;
        runlen = 0;
        nother = 0;
        for (int i = 0; i < 80; i++) begin
            if (runlen == 0) begin
                lvl = ~lvl;
                runlen = lvl ? $urandom_range(1, DB - 1) : $urandom_range(1, 5);
            end
            runlen--;
            step(lvl, 1'b0, 1'b0);
            if (o_v !== 4'b0000) nother++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (o_v !== 4'b0000) nother++;
        end
        n_cmp++;
        if (nother != 0) begin
            n_fail++;
            $display("FAIL bounce_glitch: got %0d active cycles expected 0", nother);
        end
    endtask

    task automatic test_auto_repeat();
        int t0;
        int rel;
        int decq[$];
        int expq[$];
        bit bad;
        expq = '{7, 27, 35, 43, 51, 59};
        t0 = cyc;
        for (int i = 0; i < 80; i++) begin
            step(1'b0, i < 60, 1'b0);
            rel = cyc - t0;
            n_cmp++;
            if (o_v !== e_v) begin
                n_fail++;
                $display("FAIL repeat_model rel=%0d: got %b expected %b", rel, o_v, e_v);
            end
            if (decrement_address === 1'b1) decq.push_back(rel);
        end
        bad = (decq.size() != expq.size());
        for (int k = 0; k < decq.size() && !bad; k++) if (decq[k] != expq[k]) bad = 1'b1;
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL repeat_cadence: got %p expected %p", decq, expq);
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        int rel;
        int npulse;
        int incq[$];
        t0 = cyc;
        npulse = 0;
        for (int i = 0; i < 50; i++) begin
            step(i < 30, i < 30, 1'b0);
            n_cmp++;
            if (o_v !== e_v) begin
                n_fail++;
                $display("FAIL simul_model rel=%0d: got %b expected %b", cyc - t0, o_v, e_v);
            end
            if (increment_address !== 1'b0 || decrement_address !== 1'b0) npulse++;
        end
        n_cmp++;
        if (npulse != 0) begin
            n_fail++;
            $display("FAIL simul_no_pulse: got %0d pulses expected 0", npulse);
        end
        t0 = cyc;
        for (int i = 0; i < 30; i++) begin
            step(i < 10, 1'b0, 1'b0);
            rel = cyc - t0;
            if (increment_address === 1'b1) incq.push_back(rel);
        end
        n_cmp++;
        if (incq.size() != 1 || incq[0] != 7) begin
            n_fail++;
            $display("FAIL simul_followup: got %p expected '{7}", incq);
        end
    endtask

    task automatic test_cross_press();
        int t0;
        int rel;
        int incq[$];
        int ndec;
        t0 = cyc;
        ndec = 0;
        for (int i = 0; i < 80; i++) begin
            step(i < 50, (i >= 28 && i < 60), 1'b0);
            rel = cyc - t0;
            n_cmp++;
            if (o_v !== e_v) begin
                n_fail++;
                $display("FAIL cross_model rel=%0d: got %b expected %b", rel, o_v, e_v);
            end
            if (increment_address === 1'b1) incq.push_back(rel);
            if (decrement_address !== 1'b0) ndec++;
        end
        n_cmp++;
        if (incq.size() != 2 || incq[0] != 7 || incq[1] != 27 || ndec != 0) begin
            n_fail++;
            $display("FAIL cross_lockout: got inc %p dec %0d expected inc '{7,27} dec 0", incq, ndec);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int t0;
        int rel;
        int preq[$];
        int postq[$];
        int expq[$];
        bit bad;
        expq = '{7, 27, 35, 43};
        t0 = cyc;
        for (int i = 0; i <= 40; i++) begin
            step(1'b1, 1'b0, i == 40);
            rel = cyc - t0;
            if (increment_address === 1'b1 && i < 40) preq.push_back(rel);
        end
        n_cmp++;
        if (o_v !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_clear: got %b expected 0000", o_v);
        end
        n_cmp++;
        if (preq.size() != 3 || preq[0] != 7 || preq[1] != 27 || preq[2] != 35) begin
            n_fail++;
            $display("FAIL midreset_before: got %p expected '{7,27,35}", preq);
        end
        t0 = cyc;
        for (int i = 0; i < 60; i++) begin
            step(i < 40, 1'b0, 1'b0);
            rel = cyc - t0;
            n_cmp++;
            if (o_v !== e_v) begin
                n_fail++;
                $display("FAIL midreset_model rel=%0d: got %b expected %b", rel, o_v, e_v);
            end
            if (increment_address === 1'b1) postq.push_back(rel);
        end
        bad = (postq.size() != expq.size());
        for (int k = 0; k < postq.size() && !bad; k++) if (postq[k] != expq[k]) bad = 1'b1;
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL midreset_after: got %p expected %p", postq, expq);
        end
    endtask

    task automatic test_random();
        int  left[2];
        bit  lvl[2];
        bit  rst;
        bit  prev_any;
        bit  any;
        left[0] = 0; left[1] = 0;
        lvl[0] = 1'b0; lvl[1] = 1'b0;
        prev_any = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (left[b] == 0) begin
                    lvl[b]  = ~lvl[b];
                    left[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 70);
                end
                left[b]--;
            end
            rst = ($urandom_range(0, 399) == 0);
            step(lvl[0], lvl[1], rst);
            n_cmp++;
            if (o_v !== e_v) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d: got %b expected %b", cyc, o_v, e_v);
            end
            any = (increment_address === 1'b1) || (decrement_address === 1'b1);
            n_cmp++;
            if ((increment_address === 1'b1 && decrement_address === 1'b1) || (any && prev_any)) begin
                n_fail++;
                $display("FAIL random_invariant cyc=%0d: got inc=%b dec=%b prev=%b expected exclusive isolated pulses",
                         cyc, increment_address, decrement_address, prev_any);
            end
            prev_any = any;
        end
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        inc_button_in = 1'b1;
        dec_button_in = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_cross_press();
        test_reset_mid_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout at cyc=%0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
